mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter N, default 32: data and address width.
REQ-002 Parameter MAX_WAIT, default 15: cycles mem_req may stay high without mem_ack before abort; range 1-255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  execute stage presents a result this cycle.
REQ-006 in_ready  output  1  unit accepts a result this cycle.
REQ-007 alu_ctrl  input  5  ALU opcode of the presented result; 17 = LDR, 19 = STR.
REQ-008 alu_result  input  N  ALU output: byte address for LDR/STR, the value itself otherwise.
REQ-009 store_data  input  N  register value to write on STR.
REQ-010 rd_in  input  4  destination register index.
REQ-011 mem_req  output  1  data-memory request.
REQ-012 mem_we  output  1  1 = write request, 0 = read request.
REQ-013 mem_addr  output  N  request byte address.
REQ-014 mem_wdata  output  N  write data.
REQ-015 mem_ack  input  1  memory completes the request this cycle.
REQ-016 mem_rdata  input  N  read data, valid while mem_ack is high.
REQ-017 wb_valid  output  1  one-cycle pulse per accepted result.
REQ-018 wb_we  output  1  register-file write enable for this pulse.
REQ-019 wb_rd  output  4  destination register index.
REQ-020 wb_data  output  N  writeback value.
REQ-021 mem_err  output  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-022 FSM states are IDLE and ACCESS; in_ready is 1 in IDLE and 0 in ACCESS; an acceptance is in_valid & in_ready at a clock edge.
REQ-023 A non-memory opcode accepted at edge t produces wb_valid=1 in cycle t+1, with wb_data=alu_result, wb_rd=rd_in, and the FSM stays IDLE, so throughput is one result per cycle.
REQ-024 For a non-memory opcode, wb_we=1 for opcodes 1-6 and 9-12; wb_we=0 for every other opcode, including jumps 25-30 and 0.
REQ-025 An LDR/STR accepted with alu_result[1:0]!=0 is misaligned: no request is issued, and in cycle t+1 wb_valid=1, wb_we=0, wb_data=0 and mem_err=1; the FSM stays IDLE.
REQ-026 An aligned LDR/STR accepted at edge t latches address, store_data, rd and opcode, and the FSM enters ACCESS.
REQ-027 From cycle t+1, mem_req=1, mem_addr is the latched address and mem_we=1 only for STR; mem_wdata equals the latched store_data for STR and 0 for LDR.
REQ-028 In ACCESS, mem_addr, mem_we and mem_wdata are held stable until mem_ack or abort.
REQ-029 On mem_ack=1 at edge k, the FSM returns to IDLE and mem_req drops in cycle k+1.
REQ-030 In cycle k+1, wb_valid=1; LDR gives wb_we=1 and wb_data=mem_rdata sampled at edge k; STR gives wb_we=0 and wb_data=0; in_ready=1.
REQ-031 mem_ack is ignored when the FSM is not in ACCESS.
REQ-032 A wait counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack.
REQ-033 After MAX_WAIT cycles of mem_req without mem_ack, the unit aborts: mem_req drops, FSM goes IDLE, and the next cycle has wb_valid=1, wb_we=0, wb_data=0, mem_err=1.
REQ-034 mem_ack arriving in the same cycle the counter reaches MAX_WAIT counts as success, not timeout.
REQ-035 wb_valid, wb_we and mem_err are single-cycle pulses; writeback applies no back-pressure.

Reset
REQ-036 While rst=1, independent of clk: FSM=IDLE, counter=0, and all outputs are 0 except in_ready=1.
REQ-037 rst asserted during ACCESS drops mem_req immediately; the pending access is discarded with no wb_valid and no mem_err.
REQ-038 The first acceptance is possible at the first rising edge after rst deasserts.

Verification
REQ-039 ADD back-to-back: alu_ctrl=1, alu_result=0x0000_0005, rd=3, then alu_ctrl=27 -> wb_valid on 2 consecutive cycles; (we=1, rd=3, data=5), then we=0.
REQ-040 LDR aligned: alu_result=0x100, mem_ack 3 cycles after mem_req rises, mem_rdata=0xDEAD_BEEF -> mem_req high exactly 3 cycles, mem_we=0, wb data=0xDEAD_BEEF, we=1, in_ready low for those 3 cycles.
REQ-041 STR: alu_result=0x204, store_data=0x1234_5678, ack after 1 cycle -> mem_we=1, mem_wdata=0x1234_5678, then wb_valid with we=0.
REQ-042 Misaligned LDR at 0x102 -> mem_req never rises; next cycle wb_valid=1, we=0, mem_err=1.
REQ-043 Timeout with MAX_WAIT=4 and no ack -> mem_req high 4 cycles, then mem_err=1 and wb_valid=1 with we=0; a second run with ack on the 4th cycle completes normally and mem_err=0.
REQ-044 rst pulsed asynchronously mid-ACCESS -> mem_req=0 before the next edge; no wb_valid follows; in_ready=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage: forwards ALU results to writeback and runs LDR/STR
// through a single-outstanding request/acknowledge data-memory port with timeout.
module mem_access_unit #(
  parameter int N        = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic [N-1:0] store_data,
  input  logic [3:0]   rd_in,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         wb_valid,
  output logic         wb_we,
  output logic [3:0]   wb_rd,
  output logic [N-1:0] wb_data,
  output logic         mem_err
);

  localparam logic [4:0] OP_LDR    = 5'd17;
  localparam logic [4:0] OP_STR    = 5'd19;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [N-1:0]   addr_q, addr_d;
  logic [N-1:0]   wdata_q, wdata_d;
  logic           we_q, we_d;
  logic [3:0]     rd_q, rd_d;
  logic           is_ldr_q, is_ldr_d;
  logic           wb_valid_q, wb_valid_d;
  logic           wb_we_q, wb_we_d;
  logic [3:0]     wb_rd_q, wb_rd_d;
  logic [N-1:0]   wb_data_q, wb_data_d;
  logic           err_q, err_d;

  logic           accept_s;
  logic           is_str_s;
  logic           is_mem_s;

  // Register-file write enable for non-memory opcodes (ALU ops write, jumps/others do not).
  function automatic logic op_writes_rf(input logic [4:0] op);
    return ((op >= 5'd1) && (op <= 5'd6)) || ((op >= 5'd9) && (op <= 5'd12));
  endfunction

  assign accept_s = in_valid && (state_q == IDLE);
  assign is_str_s = (alu_ctrl == OP_STR);
  assign is_mem_s = (alu_ctrl == OP_LDR) || is_str_s;

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rd_d       = rd_q;
    is_ldr_d   = is_ldr_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = 4'd0;
    wb_data_d  = '0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s && !is_mem_s) begin
          wb_valid_d = 1'b1;
          wb_we_d    = op_writes_rf(alu_ctrl);
          wb_rd_d    = rd_in;
          wb_data_d  = alu_result;
        end else if (accept_s && (alu_result[1:0] != 2'b00)) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_in;
          err_d      = 1'b1;
        end else if (accept_s) begin
          state_d  = ACCESS;
          cnt_d    = 8'd0;
          addr_d   = alu_result;
          we_d     = is_str_s;
          wdata_d  = is_str_s ? store_data : '0;
          rd_d     = rd_in;
          is_ldr_d = !is_str_s;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // An ack on the final wait cycle wins over the timeout.
        if (mem_ack || (cnt_q == WAIT_LAST)) begin
          state_d    = IDLE;
          cnt_d      = 8'd0;
          addr_d     = '0;
          wdata_d    = '0;
          we_d       = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = mem_ack && is_ldr_q;
          wb_data_d  = (mem_ack && is_ldr_q) ? mem_rdata : '0;
          err_d      = !mem_ack;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rd_q       <= 4'd0;
      is_ldr_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 4'd0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      is_ldr_q   <= is_ldr_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign mem_err   = err_q;

endmodule
